// File: rtl/circ_interp_pkg.sv
// Shared types for the circle/line interpolator: FSM states, step codes
// and the width of the deviation accumulator.
package circ_interp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STEP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    XP,
    XN,
    YP,
    YN
  } step_t;

  // Deviation accumulator width needed to hold x^2+y^2-R^2 without overflow.
  function automatic int f_width(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/circ_step_sel.sv
// Picks the next step direction from quadrant, arc direction and
// deviation sign (circular) or the Bresenham-style rule (linear).
module circ_step_sel
  import circ_interp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    i_mode,
  input  logic                    i_direct,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic signed [WIDTH-1:0] i_y,
  input  logic                    i_f_neg,
  input  logic                    i_dx_neg,
  input  logic                    i_dy_neg,
  input  logic                    i_dx_zero,
  input  logic                    i_dy_zero,
  output step_t                   o_code
);

  logic w_xn, w_xp, w_yn, w_yp;

  assign w_xn = i_x[WIDTH-1];
  assign w_yn = i_y[WIDTH-1];
  assign w_xp = !w_xn && (i_x != '0);
  assign w_yp = !w_yn && (i_y != '0);

  always_comb begin
    o_code = XP;
    if (i_mode) begin
      if (i_dy_zero || (!i_dx_zero && !i_f_neg))
        o_code = i_dx_neg ? XN : XP;
      else
        o_code = i_dy_neg ? YN : YP;
    end else if (!i_direct) begin
      // Counter-clockwise: quadrant boundaries belong to the leaving side.
      unique case (1'b1)
        (w_xp && !w_yn): o_code = i_f_neg ? YP : XN;
        (!w_xp && w_yp): o_code = i_f_neg ? XN : YN;
        (w_xn && !w_yp): o_code = i_f_neg ? YN : XP;
        (!w_xn && w_yn): o_code = i_f_neg ? XP : YP;
        default:         o_code = XP;
      endcase
    end else begin
      unique case (1'b1)
        (!w_xn && w_yp): o_code = i_f_neg ? XP : YN;
        (w_xp && !w_yp): o_code = i_f_neg ? YN : XN;
        (!w_xp && w_yn): o_code = i_f_neg ? XN : YP;
        (w_xn && !w_yn): o_code = i_f_neg ? YP : XP;
        default:         o_code = XP;
      endcase
    end
  end

endmodule

// File: rtl/circ_interp_gen.sv
// Point-by-point circle/line interpolator with feed divider and step count.
// Define POS_TRACK_EN to add the x_pos/y_pos current-point outputs.
module circ_interp_gen
  import circ_interp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV_W     = 16,
  parameter int MAX_STEPS = 2**(WIDTH+3)-1
) (
  input  logic                    pulse_clk,
  input  logic                    sys_rst_l,
  input  logic                    change_readyH,
  input  logic                    mode,
  input  logic                    direct,
  input  logic signed [WIDTH-1:0] Xs,
  input  logic signed [WIDTH-1:0] Ys,
  input  logic signed [WIDTH-1:0] Xe,
  input  logic signed [WIDTH-1:0] Ye,
  input  logic [DIV_W-1:0]        feed_div,
  output logic                    X_acc,
  output logic                    X_dec,
  output logic                    Y_acc,
  output logic                    Y_dec,
  output logic                    busy,
  output logic                    draw_overH,
  output logic                    err,
  output logic [WIDTH+2:0]        step_count
`ifdef POS_TRACK_EN
  ,
  output logic signed [WIDTH-1:0] x_pos,
  output logic signed [WIDTH-1:0] y_pos
`endif
);

  localparam int FW = f_width(WIDTH);
  localparam int CW = WIDTH + 3;

  state_t                  r_state, w_next;
  logic                    r_mode, r_dir, r_dxn, r_dyn, r_err;
  logic signed [WIDTH-1:0] r_x, r_y, r_xe, r_ye;
  logic [WIDTH:0]          r_adx, r_ady;
  logic [DIV_W-1:0]        r_div, r_feed;
  logic signed [FW-1:0]    r_f;
  logic [CW-1:0]           r_cnt;
  logic [3:0]              r_pulse;

  logic signed [WIDTH:0]   w_dx, w_dy;
  logic [WIDTH:0]          w_adx, w_ady;
  logic [WIDTH+1:0]        w_n;
  logic                    w_org, w_lzero, w_at_end;
  logic                    w_finish, w_abort, w_fire, w_set_err;
  step_t                   w_code;
  logic signed [FW-1:0]    w_xs, w_ys, w_mx, w_my, w_fnx;
  logic signed [WIDTH-1:0] w_xnx, w_ynx;

`ifdef POS_TRACK_EN
  localparam bit TRACK = 1'b1;
  assign x_pos = r_x;
  assign y_pos = r_y;
`else
  // Without tracking, x/y only matter for arcs.
  localparam bit TRACK = 1'b0;
`endif

  assign w_dx  = {r_xe[WIDTH-1], r_xe} - {r_x[WIDTH-1], r_x};
  assign w_dy  = {r_ye[WIDTH-1], r_ye} - {r_y[WIDTH-1], r_y};
  assign w_adx = w_dx[WIDTH] ? -w_dx : w_dx;
  assign w_ady = w_dy[WIDTH] ? -w_dy : w_dy;
  assign w_n   = {1'b0, r_adx} + {1'b0, r_ady};

  assign w_org    = (r_x == '0) && (r_y == '0);
  assign w_lzero  = (r_x == r_xe) && (r_y == r_ye);
  assign w_at_end = w_lzero && (r_cnt != '0);
  assign w_finish = r_mode ? (r_cnt == {1'b0, w_n}) : w_at_end;
  assign w_abort  = !r_mode && (r_cnt == CW'(MAX_STEPS));

  circ_step_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .i_mode   (r_mode),
    .i_direct (r_dir),
    .i_x      (r_x),
    .i_y      (r_y),
    .i_f_neg  (r_f[FW-1]),
    .i_dx_neg (r_dxn),
    .i_dy_neg (r_dyn),
    .i_dx_zero(r_adx == '0),
    .i_dy_zero(r_ady == '0),
    .o_code   (w_code)
  );

  assign w_xs = {{(FW-WIDTH){r_x[WIDTH-1]}}, r_x};
  assign w_ys = {{(FW-WIDTH){r_y[WIDTH-1]}}, r_y};
  assign w_mx = {{(FW-WIDTH-1){1'b0}}, r_adx};
  assign w_my = {{(FW-WIDTH-1){1'b0}}, r_ady};

  // Arc: F += 2*v*d + 1 with the pre-step coordinate v.
  always_comb begin
    w_fnx = r_f;
    w_xnx = r_x;
    w_ynx = r_y;
    unique case (w_code)
      XP: begin
        w_xnx = r_x + WIDTH'(1);
        w_fnx = r_mode ? r_f - w_my
                       : r_f + {w_xs[FW-2:0], 1'b0} + FW'(1);
      end
      XN: begin
        w_xnx = r_x - WIDTH'(1);
        w_fnx = r_mode ? r_f - w_my
                       : r_f - {w_xs[FW-2:0], 1'b0} + FW'(1);
      end
      YP: begin
        w_ynx = r_y + WIDTH'(1);
        w_fnx = r_mode ? r_f + w_mx
                       : r_f + {w_ys[FW-2:0], 1'b0} + FW'(1);
      end
      YN: begin
        w_ynx = r_y - WIDTH'(1);
        w_fnx = r_mode ? r_f + w_mx
                       : r_f - {w_ys[FW-2:0], 1'b0} + FW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_fire    = 1'b0;
    w_set_err = 1'b0;
    unique case (r_state)
      IDLE: if (change_readyH) w_next = LOAD;
      LOAD: begin
        if (r_mode ? w_lzero : w_org) begin
          w_next    = DONE;
          w_set_err = !r_mode;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_div == '0) begin
          w_next = STEP;
          w_fire = 1'b1;
        end
      end
      STEP: begin
        if (w_finish) begin
          w_next = DONE;
        end else if (w_abort) begin
          w_next    = DONE;
          w_set_err = 1'b1;
        end else if (r_feed == '0) begin
          w_next = STEP;
          w_fire = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_mode  <= 1'b0;
      r_dir   <= 1'b0;
      r_dxn   <= 1'b0;
      r_dyn   <= 1'b0;
      r_err   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_xe    <= '0;
      r_ye    <= '0;
      r_adx   <= '0;
      r_ady   <= '0;
      r_div   <= '0;
      r_feed  <= '0;
      r_f     <= '0;
      r_cnt   <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      unique case (r_state)
        IDLE: begin
          if (change_readyH) begin
            r_mode <= mode;
            r_dir  <= direct;
            r_x    <= Xs;
            r_y    <= Ys;
            r_xe   <= Xe;
            r_ye   <= Ye;
            r_feed <= feed_div;
          end
        end
        LOAD: begin
          r_cnt <= '0;
          r_err <= w_set_err;
          r_div <= r_feed;
          r_f   <= '0;
          r_adx <= w_adx;
          r_ady <= w_ady;
          r_dxn <= w_dx[WIDTH];
          r_dyn <= w_dy[WIDTH];
        end
        WAIT: if (r_div != '0) r_div <= r_div - DIV_W'(1);
        // The hop back into WAIT costs one clock, hence feed-1.
        STEP: begin
          if (w_set_err) r_err <= 1'b1;
          r_div <= r_feed - DIV_W'(1);
        end
        default: ;
      endcase
      if (w_fire) begin
        r_f     <= w_fnx;
        r_cnt   <= r_cnt + CW'(1);
        r_pulse <= 4'b0001 << w_code;
        if (!r_mode || TRACK) begin
          r_x <= w_xnx;
          r_y <= w_ynx;
        end
      end
    end
  end

  assign X_acc      = r_pulse[0];
  assign X_dec      = r_pulse[1];
  assign Y_acc      = r_pulse[2];
  assign Y_dec      = r_pulse[3];
  assign busy       = (r_state != IDLE);
  assign draw_overH = (r_state == DONE);
  assign err        = r_err;
  assign step_count = r_cnt;

endmodule

// File: tb/tb_circ_interp_gen.sv
// Directed self-checking bench for circ_interp_gen (arcs, lines, feed
// divider, error aborts and mid-move reset).
module tb_circ_interp_gen;

  logic        pulse_clk;
  logic        sys_rst_l;
  logic        change_readyH;
  logic        mode;
  logic        direct;
  logic [15:0] Xs, Ys, Xe, Ye;
  logic [15:0] feed_div;
  logic        X_acc, X_dec, Y_acc, Y_dec;
  logic        busy, draw_overH, err;
  logic [18:0] step_count;
`ifdef POS_TRACK_EN
  logic [15:0] x_pos, y_pos;
`endif

  int checks   = 0;
  int failures = 0;

  int np, n_xa, n_xd, n_ya, n_yd;
  int first_at, last_at, done_at;
  int gap_bad, multi, busy_bad;
  int fx, fy, ymin;
  int fin_err, fin_cnt, ord;

  circ_interp_gen #(
    .WIDTH    (16),
    .DIV_W    (16),
    .MAX_STEPS(200)
  ) dut (
    .pulse_clk    (pulse_clk),
    .sys_rst_l    (sys_rst_l),
    .change_readyH(change_readyH),
    .mode         (mode),
    .direct       (direct),
    .Xs           (Xs),
    .Ys           (Ys),
    .Xe           (Xe),
    .Ye           (Ye),
    .feed_div     (feed_div),
    .X_acc        (X_acc),
    .X_dec        (X_dec),
    .Y_acc        (Y_acc),
    .Y_dec        (Y_dec),
    .busy         (busy),
    .draw_overH   (draw_overH),
    .err          (err),
    .step_count   (step_count)
`ifdef POS_TRACK_EN
    ,
    .x_pos        (x_pos),
    .y_pos        (y_pos)
`endif
  );

  initial pulse_clk = 1'b0;
  always #5 pulse_clk = ~pulse_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic observe(input int k, input int fd);
    logic [3:0] p;
    p = {Y_dec, Y_acc, X_dec, X_acc};
    if (!busy) busy_bad++;
    if ($countones(p) > 1) multi++;
    if (p != 4'b0) begin
      np++;
      if (first_at < 0) first_at = k;
      else if (k - last_at != fd + 1) gap_bad++;
      last_at = k;
      if (np <= 7) ord = (ord << 4) | int'(p);
      if (X_acc) begin n_xa++; fx++; end
      if (X_dec) begin n_xd++; fx--; end
      if (Y_acc) begin n_ya++; fy++; end
      if (Y_dec) begin n_yd++; fy--; end
      if (fy < ymin) ymin = fy;
    end
    if (draw_overH) begin
      done_at = k;
      fin_err = int'(err);
      fin_cnt = int'(step_count);
    end
  endtask

  task automatic clear_stats(input int xs, input int ys);
    np = 0; n_xa = 0; n_xd = 0; n_ya = 0; n_yd = 0;
    first_at = -1; last_at = -1; done_at = -1;
    gap_bad = 0; multi = 0; busy_bad = 0;
    fx = xs; fy = ys; ymin = ys;
    fin_err = -1; fin_cnt = -1; ord = 0;
  endtask

  task automatic launch(input logic m, input logic d, input int xs,
                        input int ys, input int xe, input int ye,
                        input int fd);
    mode = m; direct = d;
    Xs = 16'(xs); Ys = 16'(ys); Xe = 16'(xe); Ye = 16'(ye);
    feed_div = 16'(fd);
    change_readyH = 1'b1;
    @(negedge pulse_clk);
    change_readyH = 1'b0;
  endtask

  task automatic run_move(input logic m, input logic d, input int xs,
                          input int ys, input int xe, input int ye,
                          input int fd, input int poke, input int budget);
    int k;
    clear_stats(xs, ys);
    launch(m, d, xs, ys, xe, ye, fd);
    k = 0;
    while (done_at < 0 && k < budget) begin
      @(negedge pulse_clk);
      k++;
      observe(k, fd);
      if (k == poke) begin
        change_readyH = 1'b1;
        Xe = Xe ^ 16'h0005;
      end else begin
        change_readyH = 1'b0;
      end
    end
    chk("move_finished", int'(done_at >= 0), 1);
    @(negedge pulse_clk);
    if (busy || draw_overH) busy_bad++;
    change_readyH = 1'b0;
  endtask

  initial begin
    sys_rst_l = 1'b0;
    change_readyH = 1'b0;
    mode = 1'b0; direct = 1'b0;
    Xs = '0; Ys = '0; Xe = '0; Ye = '0; feed_div = '0;
    repeat (3) @(negedge pulse_clk);
    chk("reset_outs", int'({X_acc, X_dec, Y_acc, Y_dec, busy, draw_overH, err}), 0);
    chk("reset_cnt", int'(step_count), 0);
    sys_rst_l = 1'b1;
    @(negedge pulse_clk);

    // CW half circle over the top, full speed
    run_move(1'b0, 1'b1, -10, 0, 10, 0, 0, -1, 200);
    chk("cw_pulses", np, 40);
    chk("cw_xacc", n_xa, 20);
    chk("cw_yacc", n_ya, 10);
    chk("cw_ydec", n_yd, 10);
    chk("cw_xdec", n_xd, 0);
    chk("cw_ymin", ymin, 0);
    chk("cw_end_x", fx, 10);
    chk("cw_end_y", fy, 0);
    chk("cw_first", first_at, 2);
    chk("cw_gap", gap_bad, 0);
    chk("cw_done_lat", done_at - last_at, 1);
    chk("cw_count", fin_cnt, 40);
    chk("cw_err", fin_err, 0);
    chk("cw_onehot", multi, 0);
    chk("cw_busy", busy_bad, 0);

    // CCW full circle
    run_move(1'b0, 1'b0, 10, 0, 10, 0, 0, -1, 200);
    chk("ccw_pulses", np, 80);
    chk("ccw_xacc", n_xa, 20);
    chk("ccw_xdec", n_xd, 20);
    chk("ccw_yacc", n_ya, 20);
    chk("ccw_ydec", n_yd, 20);
    chk("ccw_count", fin_cnt, 80);
    chk("ccw_err", fin_err, 0);

    // line (0,0)->(3,2): X Y X Y X, with a start poked mid-move
    run_move(1'b1, 1'b0, 0, 0, 3, 2, 0, 3, 50);
    chk("lin_order", ord, 32'h14141);
    chk("lin_count", fin_cnt, 5);
    chk("lin_pulses", np, 5);
    chk("lin_done_lat", done_at - last_at, 1);
    chk("lin_busy", busy_bad, 0);

    // zero-length line
    run_move(1'b1, 1'b0, 5, 5, 5, 5, 0, -1, 20);
    chk("lz_pulses", np, 0);
    chk("lz_done_at", done_at, 1);
    chk("lz_err", fin_err, 0);

    // divided feed, -X line
    run_move(1'b1, 1'b0, 0, 0, -4, 0, 3, -1, 100);
    chk("fd_xdec", n_xd, 4);
    chk("fd_pulses", np, 4);
    chk("fd_first", first_at, 5);
    chk("fd_gap", gap_bad, 0);
    chk("fd_count", fin_cnt, 4);

    // arc from the centre is an error
    run_move(1'b0, 1'b0, 0, 0, 5, 5, 0, -1, 20);
    chk("org_err", fin_err, 1);
    chk("org_pulses", np, 0);
    chk("org_done_at", done_at, 1);

    // unreachable arc end aborts at MAX_STEPS
    run_move(1'b0, 1'b0, 10, 0, 7, 3, 0, -1, 400);
    chk("abort_err", fin_err, 1);
    chk("abort_count", fin_cnt, 200);
    chk("abort_pulses", np, 200);
    repeat (4) @(negedge pulse_clk);
    chk("err_held", int'(err), 1);

    // reset in the middle of a move, together with a start request
    clear_stats(-10, 0);
    launch(1'b0, 1'b1, -10, 0, 10, 0, 1);
    for (int i = 0; i < 100 && np < 6; i++) begin
      @(negedge pulse_clk);
      observe(i + 1, 1);
    end
    chk("rst_reach6", np, 6);
    sys_rst_l = 1'b0;
    change_readyH = 1'b1;
    #1;
    chk("rst_async", int'({X_acc, X_dec, Y_acc, Y_dec, busy, draw_overH, err}), 0);
    chk("rst_async_cnt", int'(step_count), 0);
    @(negedge pulse_clk);
    chk("rst_wins", int'(busy), 0);
    change_readyH = 1'b0;
    sys_rst_l = 1'b1;
    @(negedge pulse_clk);
    chk("rst_idle", int'({busy, step_count}), 0);

    // clean move after reset, start poked while busy
    run_move(1'b1, 1'b0, 0, 0, 2, -3, 0, 3, 50);
    chk("post_order", ord, 32'h18818);
    chk("post_xacc", n_xa, 2);
    chk("post_ydec", n_yd, 3);
    chk("post_count", fin_cnt, 5);
    chk("post_end", fx * 100 + fy, 197);
    chk("post_busy", busy_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
